// File: rtl/lfsr_scrambler.sv
// AXI-Stream LFSR scrambler/descrambler (additive or self-synchronising), WIDTH bits per beat in one cycle.
// Latency 1 cycle; single output register, input stalls only while the held output beat is not taken.
module lfsr_scrambler #(
  parameter int                  WIDTH          = 24,
  parameter int                  LFSR_LEN       = 7,
  parameter logic [LFSR_LEN-1:0] POLY           = 7'b1001000,
  parameter logic [LFSR_LEN-1:0] SEED           = 7'b1011101,
  parameter int                  MODE           = 0,
  parameter int                  RESEED_ON_LAST = 1
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [WIDTH-1:0]    s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [WIDTH-1:0]    m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  input  logic [LFSR_LEN-1:0] s_seed_tdata,
  input  logic                s_seed_tvalid,
  output logic                s_seed_tready
);

  logic [LFSR_LEN-1:0] lfsr_state;
  logic [LFSR_LEN-1:0] seed_reg;
  logic [LFSR_LEN-1:0] walk;
  logic [LFSR_LEN-1:0] next_state;
  logic [WIDTH-1:0]    proc_dat;
  logic [WIDTH-1:0]    out_dat;
  logic                out_vld;
  logic                out_last;
  logic                fb;
  logic                din;
  logic                obit;
  logic                sin;
  logic                accept;

  // Unrolled bit-serial walk: MSB of the beat is the first bit on the wire.
  always_comb begin
    walk     = lfsr_state;
    proc_dat = '0;
    fb       = 1'b0;
    din      = 1'b0;
    obit     = 1'b0;
    sin      = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      fb          = ^(POLY & walk);
      din         = s_axis_tdata[i];
      obit        = din ^ fb;
      proc_dat[i] = obit;
      if (MODE == 1) begin
        sin = obit;
      end else if (MODE == 2) begin
        sin = din;
      end else begin
        sin = fb;
      end
      walk = {walk[LFSR_LEN-2:0], sin};
    end
    next_state = walk;
  end

  assign s_axis_tready = !out_vld || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign s_seed_tready = 1'b1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr_state <= SEED;
      seed_reg   <= SEED;
      out_dat    <= '0;
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (accept) begin
        out_dat  <= proc_dat;
        out_last <= s_axis_tlast;
        out_vld  <= 1'b1;
      end else if (m_axis_tready) begin
        out_vld  <= 1'b0;
      end

      // A seed load overrides both the per-beat advance and the end-of-packet reload.
      if (s_seed_tvalid) begin
        seed_reg   <= s_seed_tdata;
        lfsr_state <= s_seed_tdata;
      end else if (accept) begin
        if ((RESEED_ON_LAST != 0) && s_axis_tlast) begin
          lfsr_state <= seed_reg;
        end else begin
          lfsr_state <= next_state;
        end
      end
    end
  end

  assign m_axis_tdata  = out_dat;
  assign m_axis_tvalid = out_vld;
  assign m_axis_tlast  = out_last;

endmodule

// File: tb/tb_lfsr_scrambler.sv
// Directed bench for lfsr_scrambler: 802.11 vectors, seed/reseed, backpressure, loopback, reset.
module tb_lfsr_scrambler;

  logic       aclk   = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] s_dat  = '0;
  logic       s_vld  = 1'b0;
  logic       s_last = 1'b0;
  logic       m_rdy  = 1'b1;
  logic [6:0] sd_dat = '0;
  logic       sd_vld = 1'b0;

  logic       a_s_rdy, a_vld, a_last, a_sd_rdy;
  logic [7:0] a_dat;
  logic       b_s_rdy, b_vld, b_last, b_sd_rdy;
  logic [7:0] b_dat;

  logic [23:0] ls_dat = '0;
  logic        ls_vld = 1'b0;
  logic        ls_last = 1'b0;
  logic        ls_rdy;
  logic [23:0] mid_dat;
  logic        mid_vld, mid_last, mid_rdy;
  logic [23:0] ld_dat;
  logic        ld_vld, ld_last;
  logic        ld_rdy = 1'b1;
  logic [6:0]  lb_sd_dat = '0;
  logic        lb_sd_vld = 1'b0;
  logic        us_sd_rdy, ud_sd_rdy;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  lfsr_scrambler #(.WIDTH(8), .MODE(0), .RESEED_ON_LAST(1)) u_a (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tready(a_s_rdy), .s_axis_tlast(s_last),
    .m_axis_tdata(a_dat), .m_axis_tvalid(a_vld), .m_axis_tready(m_rdy), .m_axis_tlast(a_last),
    .s_seed_tdata(sd_dat), .s_seed_tvalid(sd_vld), .s_seed_tready(a_sd_rdy));

  lfsr_scrambler #(.WIDTH(8), .MODE(0), .RESEED_ON_LAST(0)) u_b (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tready(b_s_rdy), .s_axis_tlast(s_last),
    .m_axis_tdata(b_dat), .m_axis_tvalid(b_vld), .m_axis_tready(m_rdy), .m_axis_tlast(b_last),
    .s_seed_tdata(sd_dat), .s_seed_tvalid(sd_vld), .s_seed_tready(b_sd_rdy));

  lfsr_scrambler #(.WIDTH(24), .MODE(1), .SEED(7'b1011101)) u_s (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(ls_dat), .s_axis_tvalid(ls_vld), .s_axis_tready(ls_rdy), .s_axis_tlast(ls_last),
    .m_axis_tdata(mid_dat), .m_axis_tvalid(mid_vld), .m_axis_tready(mid_rdy), .m_axis_tlast(mid_last),
    .s_seed_tdata(lb_sd_dat), .s_seed_tvalid(lb_sd_vld), .s_seed_tready(us_sd_rdy));

  lfsr_scrambler #(.WIDTH(24), .MODE(2), .SEED(7'b0000001)) u_d (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(mid_dat), .s_axis_tvalid(mid_vld), .s_axis_tready(mid_rdy), .s_axis_tlast(mid_last),
    .m_axis_tdata(ld_dat), .m_axis_tvalid(ld_vld), .m_axis_tready(ld_rdy), .m_axis_tlast(ld_last),
    .s_seed_tdata(lb_sd_dat), .s_seed_tvalid(lb_sd_vld), .s_seed_tready(ud_sd_rdy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference PN generator written as the recurrence p[n] = p[n-7] ^ p[n-4].
  logic pq[$];

  task automatic pn_reset(input logic [6:0] seed);
    pq.delete();
    for (int k = 7; k >= 1; k--) pq.push_back(seed[k-1]);
  endtask

  task automatic model_beat(input logic [7:0] d, input logic l, output logic [8:0] r);
    logic p;
    r = {l, 8'h00};
    for (int i = 7; i >= 0; i--) begin
      p = pq[0] ^ pq[3];
      r[i] = d[i] ^ p;
      pq.push_back(p);
      void'(pq.pop_front());
    end
    if (l) pn_reset(7'b1011101);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_vld  = 1'b0;
    s_last = 1'b0;
    sd_vld = 1'b0;
    ls_vld = 1'b0;
    m_rdy  = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic sv, input logic [6:0] sd);
    s_vld  = v;
    s_dat  = d;
    s_last = l;
    sd_vld = sv;
    sd_dat = sd;
    @(posedge aclk);
    #1;
    s_vld  = 1'b0;
    s_last = 1'b0;
    sd_vld = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0]  r;
    logic [8:0]  q[$];
    logic [8:0]  held;
    logic        stalled;
    logic        accepted;
    int          acc;
    int          got;
    int          cyc;
    logic [23:0] lb_in[16];
    logic [23:0] lb_out[$];

    // Reset state
    do_reset();
    chk("rst_vld",  32'(a_vld),  32'h0);
    chk("rst_dat",  32'(a_dat),  32'h0);
    chk("rst_last", 32'(a_last), 32'h0);
    chk("rst_srdy", 32'({a_s_rdy, b_s_rdy, a_sd_rdy, b_sd_rdy}), 32'hF);

    // 802.11 sequence from the default seed
    drive(1, 8'h00, 0, 0, '0);
    chk("t1_b0",  32'({a_vld, a_last, a_dat}), 32'h26C);
    drive(1, 8'h00, 0, 0, '0);
    chk("t1_b1",  32'(a_dat), 32'h19);
    drive(1, 8'h00, 0, 0, '0);
    chk("t1_b2",  32'(a_dat), 32'hA9);

    // 127 beats = 8 full periods, so the next beat restarts the sequence
    do_reset();
    for (int i = 0; i < 127; i++) drive(1, 8'h00, 0, 0, '0);
    drive(1, 8'h00, 0, 0, '0);
    chk("t1_period", 32'(a_dat), 32'h6C);

    // Seed load, then reseed on tlast (u_a) versus free-running (u_b)
    do_reset();
    drive(0, 8'h00, 0, 1, 7'h7F);
    chk("t2_seed_novld", 32'(a_vld), 32'h0);
    drive(1, 8'h00, 0, 0, '0);
    chk("t2_a_b0", 32'(a_dat), 32'h0E);
    chk("t2_b_b0", 32'(b_dat), 32'h0E);
    drive(1, 8'h00, 1, 0, '0);
    chk("t2_a_b1", 32'({a_last, a_dat}), 32'h1F2);
    chk("t2_b_b1", 32'({b_last, b_dat}), 32'h1F2);
    drive(1, 8'h00, 0, 0, '0);
    chk("t2_a_reseed", 32'(a_dat), 32'h0E);
    chk("t2_b_cont",   32'(b_dat), 32'hC9);

    // Seed load coinciding with an accepted tlast beat
    do_reset();
    drive(1, 8'h00, 1, 1, 7'h55);
    chk("t5_oldstate", 32'(a_dat), 32'h6C);
    drive(1, 8'h00, 0, 0, '0);
    chk("t5_a_new", 32'(a_dat), 32'hF4);
    chk("t5_b_new", 32'(b_dat), 32'hF4);
    drive(1, 8'h00, 1, 0, '0);
    drive(1, 8'h00, 0, 0, '0);
    chk("t5_a_reseed55", 32'(a_dat), 32'hF4);

    // Random backpressure against the reference model
    do_reset();
    pn_reset(7'b1011101);
    q.delete();
    stalled = 1'b0;
    held = '0;
    acc = 0;
    got = 0;
    cyc = 0;
    while ((acc < 200 || q.size() != 0) && cyc < 4000) begin
      if (stalled) chk("bp_hold", 32'({a_vld, a_last, a_dat}), 32'({1'b1, held}));
      if (!s_vld && acc < 200 && $urandom_range(0, 3) != 0) begin
        s_vld  = 1'b1;
        s_dat  = 8'($urandom);
        s_last = ($urandom_range(0, 9) == 0);
      end
      m_rdy = (acc >= 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      chk("bp_mvld", 32'(a_vld), 32'(q.size() != 0));
      chk("bp_srdy", 32'(a_s_rdy), 32'((q.size() == 0) || m_rdy));
      if (a_vld && m_rdy) begin
        if (q.size() == 0) begin
          chk("bp_extra", 32'(1), 32'(0));
        end else begin
          chk("bp_beat", 32'({a_last, a_dat}), 32'(q.pop_front()));
          got++;
        end
      end
      stalled  = a_vld && !m_rdy;
      held     = {a_last, a_dat};
      accepted = s_vld && a_s_rdy;
      if (accepted) begin
        model_beat(s_dat, s_last, r);
        q.push_back(r);
        acc++;
      end
      @(posedge aclk);
      #1;
      if (accepted) begin
        s_vld  = 1'b0;
        s_last = 1'b0;
      end
      cyc++;
    end
    chk("bp_count", 32'(got), 32'd200);

    // Self-sync scrambler into descrambler with a different seed
    do_reset();
    for (int j = 0; j < 16; j++) lb_in[j] = 24'($urandom);
    lb_out.delete();
    for (int j = 0; j < 16; j++) begin
      ls_dat = lb_in[j];
      ls_vld = 1'b1;
      @(posedge aclk);
      #1;
      if (ld_vld) lb_out.push_back(ld_dat);
    end
    ls_vld = 1'b0;
    for (int k = 0; k < 10 && lb_out.size() < 16; k++) begin
      @(posedge aclk);
      #1;
      if (ld_vld) lb_out.push_back(ld_dat);
    end
    chk("lb_count", 32'(lb_out.size()), 32'd16);
    if (lb_out.size() == 16) begin
      chk("lb_b0_tail", 32'(lb_out[0][16:0]), 32'(lb_in[0][16:0]));
      for (int j = 1; j < 16; j++) chk("lb_beat", 32'(lb_out[j]), 32'(lb_in[j]));
    end
    chk("lb_misc", 32'({ld_last, us_sd_rdy, ud_sd_rdy, ls_rdy}), 32'h7);

    // Reset while an output beat is stalled
    do_reset();
    m_rdy = 1'b0;
    drive(1, 8'h5A, 1, 0, '0);
    s_vld = 1'b1;
    s_dat = 8'h33;
    #1;
    chk("t6_srdy_stall", 32'({a_s_rdy, b_s_rdy}), 32'h0);
    chk("t6_held", 32'({a_vld, a_last, a_dat}), 32'h336);
    @(posedge aclk);
    #1;
    chk("t6_still", 32'({a_vld, a_last, a_dat}), 32'h336);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    s_vld  = 1'b0;
    chk("t6_rst", 32'({a_vld, a_last, a_dat, b_vld, b_last, b_dat}), 32'h0);
    m_rdy = 1'b1;
    drive(1, 8'h00, 0, 0, '0);
    chk("t6_first", 32'(a_dat), 32'h6C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_scrambler.md
Name: lfsr_scrambler

Overview:
- Parametrised AXI-Stream scrambler/descrambler; successor to the fixed 802.11 x^7+x^4+1 scrambler.
- Generalises:
  - LFSR length and polynomial.
  - Beat width.
  - Mode: additive, self-synchronising scramble, self-synchronising descramble.
  - Runtime seed load.
  - Optional automatic reseed at packet end.
- Sits between framing and modulation in the TX chain; descramble mode sits in RX after demapping.

Parameters:
- WIDTH, 24, data bits per beat (>=1).
- LFSR_LEN, 7, LFSR length N (2..32).
- POLY, 7'b1001000, tap mask of N bits; POLY[k-1]=1 means term x^k. Default is x^7+x^4+1.
- SEED, 7'b1011101, reset and default seed value (N bits).
- MODE, 0:
  - 0 = additive.
  - 1 = self-sync scramble.
  - 2 = self-sync descramble.
- RESEED_ON_LAST, 1: when 1, state reloads from the seed register after each accepted tlast beat.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- s_axis_tdata  in  WIDTH  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata  out  WIDTH  processed data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  tlast, delayed with its data.
- s_seed_tdata  in  LFSR_LEN  new seed.
- s_seed_tvalid  in  1  seed load strobe.
- s_seed_tready  out  1  constant 1.

Behaviour:
- Reset (areset high at aclk edge):
  - state <= SEED, seed_reg <= SEED.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Reset mid-packet discards the held output beat.
- State s[N-1:0]: s[0] is the newest bit, s[k-1] is the bit delayed k.
- Per bit:
  - fb = XOR over k of (POLY[k-1] & s[k-1]).
  - Output bit o = d ^ fb.
- Shift-in bit:
  - MODE 0: fb.
  - MODE 1: o.
  - MODE 2: d.
  - Update: s <= {s[N-2:0], shift-in bit}.
- Bit order: tdata[WIDTH-1] is processed first, tdata[0] last. A beat advances state by exactly WIDTH steps in one cycle (unrolled combinational loop).
- Handshake:
  - Single output register stage.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational).
  - Accept = s_axis_tvalid && s_axis_tready.
  - On accept: output regs load o, tlast, and m_axis_tvalid <= 1; state advances.
  - Else if m_axis_tready: m_axis_tvalid <= 0.
- Latency 1 cycle; full throughput of one beat per cycle with m_axis_tready held high.
- Output is held stable while m_axis_tvalid && !m_axis_tready.
- State never advances without accept.
- Seed load (s_seed_tvalid=1):
  - seed_reg <= s_seed_tdata.
  - state <= s_seed_tdata, overriding any advance that cycle.
  - A data beat accepted in the same cycle is processed with the old state.
- Reseed on last (RESEED_ON_LAST=1): an accepted beat with s_axis_tlast=1 sets state <= seed_reg after processing. A simultaneous seed load wins and uses the new seed.
- All-zero state in MODE 0: fb stays 0 and output equals input. This is legal and is not flagged.
- MODE 1 and MODE 2 with the same POLY are inverses. A descrambler with any seed converges after N bits.

Test Plan:
1. WIDTH=8, defaults, MODE 0: zero data, three beats, o_tready=1 -> m_axis_tdata 8'h6C, 8'h19, then reference-model value. Beats 1 and 2 match the 802.11 sequence 01101100 00011001. After 127 bits the sequence repeats.
2. Seed reload and reseed: WIDTH=8, MODE 0, s_seed_tdata=7'b1111111 pulsed, then zero data -> first beat 8'h0E (00001110). Beat with tlast=1, then next beat -> equals first beat again (reseed). Repeat with RESEED_ON_LAST=0 -> sequence continues.
3. Backpressure: random m_axis_tready and s_axis_tvalid over 200 beats -> output stream bit-exact to the model. No duplicated or dropped beats. tdata/tlast stable while stalled. s_axis_tready=0 only when the output is held and m_axis_tready=0.
4. Loopback: MODE 1 (seed 7'b1011101) feeding a MODE 2 instance (seed 7'b0000001), random data, WIDTH=24 -> descrambled output equals input from bit 8 onward (after N=7 bits).
5. Simultaneous events: accept beat with tlast=1 in the same cycle as seed load 7'h55 -> that beat uses the old state; the next beat starts from 7'h55.
6. Reset mid-stream: areset asserted while m_axis_tvalid=1 and stalled -> next cycle m_axis_tvalid=0, tdata=0, tlast=0. First post-reset zero beat equals the test 1 first beat (8'h6C).
